alu_share_arb: RTL and testbench
================================

# alu_share_arb

Execute-stage arbiter that shares the single 64-bit ALU (add/sub/and/xor) between two requesters: requester 0 is the pipeline's OPq/address path, requester 1 is an auxiliary client. Grants are round-robin. It holds one registered result with a valid/ready output handshake and owns the Y86-64 condition-code register (ZF/SF/OF). It sits between decode-side operand latches and the E→M pipeline register.

## Interface
- WIDTH, 64, operand/result width in bits
- TAGW, 4, opaque request tag width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-high
- reqN_valid  in  1  request N (N=0,1) presents an operation
- reqN_ready  out  1  request N accepted this cycle
- reqN_fn  in  2  function code: 0 ADD, 1 SUB, 2 AND, 3 XOR
- reqN_a, reqN_b  in  WIDTH  operands (valA, valB)
- reqN_tag  in  TAGW  returned unchanged with the result
- req0_setcc  in  1  the accepted req0 operation updates the CC register
- cc_hold  in  1  suppresses any CC update this cycle (downstream exception)
- rsp_valid  out  1  result register holds a result
- rsp_ready  in  1  consumer takes the result
- rsp_data  out  WIDTH  result
- rsp_src  out  1  requester index of the result
- rsp_tag  out  TAGW  tag of the result
- rsp_flags  out  3  {ZF,SF,OF} computed for this result
- cc  out  3  CC register {ZF,SF,OF}

## Operation
- Results: ADD b+a; SUB b−a; AND b&a; XOR b^a. All are two's-complement, truncated to WIDTH.
- ZF = result==0. SF = result[WIDTH−1]. OF for ADD: a and b have the same sign and the result sign differs. OF for SUB: a and b have different signs and the result sign differs from b. OF is 0 for AND and XOR.
- Slot free: `free = !rsp_valid || rsp_ready`, combinational from rsp_ready.
- Arbitration: when free and exactly one reqN_valid, grant N. When free and both are valid, grant the requester other than `last_grant`.
- `last_grant` updates only on an accepted request.
- reqN_ready = free && granted(N). A requester that is not granted sees ready=0 and must hold its request stable.
- On acceptance: the result register loads data, src, tag and flags, and rsp_valid=1.
- If free but no request is accepted, rsp_valid clears once rsp_ready drains the current result.
- CC updates at acceptance only when all hold: req0 is the granted requester, req0_setcc=1, and cc_hold=0. CC takes that operation's flags.
- Requester 1 never writes CC.
- State is a 2-state FSM, EMPTY / FULL, equivalent to rsp_valid:
  - EMPTY→FULL on accept.
  - FULL→FULL on drain+accept.
  - FULL→EMPTY on drain without accept.

## Timing
- Latency: a request accepted at edge N produces rsp_valid=1 with its result visible after edge N.
- Throughput: 1 op/cycle while rsp_ready=1.
- rsp_ready=0 while FULL: both reqN_ready are 0, and rsp_* and cc stay stable.
- Reset values: rsp_valid=0, rsp_data=0, rsp_src=0, rsp_tag=0, rsp_flags=3'b000, cc=3'b100 (ZF=1), last_grant=1, so req0 wins the first tie.
- Reset mid-operation: an in-flight result is discarded, not delivered; no CC update occurs in that cycle.
- cc_hold applies in the same cycle as acceptance; the result itself is still delivered.

## Configuration
- ALU_CC_EN defined: CC register and update logic are present as described.
- Not defined:
  - No CC register; cc is tied to 3'b100.
  - req0_setcc and cc_hold are ignored.
  - rsp_flags is still produced.

## Structure
- Package alu_pkg:
  - Function-code constants ALU_ADD/ALU_SUB/ALU_AND/ALU_XOR.
  - CC bit indices CC_ZF=2, CC_SF=1, CC_OF=0.
  - FSM state enum {ST_EMPTY, ST_FULL}.
- Sub-module alu64_core: combinational fn/a/b → result and {ZF,SF,OF}, parameterised by WIDTH.
- The arbiter, result register and CC register live in alu_share_arb.

## Test plan
- req0 AND, a=64'hF0F0F0F0F0F0F0F4, b=64'hCCCCCCCCCCCCCCC5 → next cycle rsp_data=64'hC0C0C0C0C0C0C0C4, flags=3'b010, src=0.
- req0 SUB, setcc=1, a=1, b=64'h8000000000000000 → rsp_data=64'h7FFFFFFFFFFFFFFF, flags=3'b001, cc=3'b001. Repeat with cc_hold=1 → cc unchanged.
- req1 ADD, a=5, b=−5 → rsp_data=0, flags=3'b100, cc unchanged (still 3'b100 after reset).
- Both requesters valid continuously, rsp_ready=1 for 4 cycles → rsp_src sequence 0,1,0,1 with one result per cycle.
- rsp_ready=0 for 3 cycles while FULL → reqN_ready=0 and rsp_data stable. Raise rsp_ready → the pending requester is accepted in that same cycle.
- Assert rst while FULL with a setcc op in flight → rsp_valid=0 and cc=3'b100 immediately, before the next clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU function codes, CC bit indices and result-slot states
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu64_core.sv
// rtl/alu64_core.sv - combinational add/sub/and/xor datapath with {ZF,SF,OF} flags
module alu64_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [1:0]       fn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    logic sa, sb, sr;

    always_comb begin
        result = '0;
        flags  = 3'b000;
        unique case (fn)
            ALU_ADD: result = b + a;
            ALU_SUB: result = b - a;
            ALU_AND: result = b & a;
            ALU_XOR: result = b ^ a;
        endcase
        sa = a[WIDTH-1];
        sb = b[WIDTH-1];
        sr = result[WIDTH-1];
        flags[CC_ZF] = (result == '0);
        flags[CC_SF] = sr;
        // Operand order is b op a, so subtraction overflow is judged against b's sign.
        if (fn == ALU_ADD) begin
            flags[CC_OF] = (sa == sb) && (sr != sa);
        end else if (fn == ALU_SUB) begin
            flags[CC_OF] = (sa != sb) && (sr != sb);
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin share of one ALU between two requesters; CC register under ALU_CC_EN
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_fn,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [TAGW-1:0]  req0_tag,
    input  logic             req0_setcc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_fn,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [TAGW-1:0]  req1_tag,
    input  logic             cc_hold,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_src,
    output logic [TAGW-1:0]  rsp_tag,
    output logic [2:0]       rsp_flags,
    output logic [2:0]       cc
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             src_q, src_d;
    logic [TAGW-1:0]  tag_q, tag_d;
    logic [2:0]       flags_q, flags_d;
    logic             last_grant_q, last_grant_d;

    logic             free, gnt0, gnt1, accept, sel;
    logic [1:0]       op_fn;
    logic [WIDTH-1:0] op_a, op_b, alu_result;
    logic [2:0]       alu_flags;

    always_comb begin
        free   = (state_q == ST_EMPTY) || rsp_ready;
        // On a tie the requester that did not win last time is preferred.
        gnt0   = req0_valid && (!req1_valid || last_grant_q);
        gnt1   = req1_valid && (!req0_valid || !last_grant_q);
        accept = free && (gnt0 || gnt1);
        sel    = gnt1;
        op_fn  = sel ? req1_fn : req0_fn;
        op_a   = sel ? req1_a  : req0_a;
        op_b   = sel ? req1_b  : req0_b;
    end

    alu64_core #(.WIDTH(WIDTH)) u_alu (
        .fn     (op_fn),
        .a      (op_a),
        .b      (op_b),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        src_d        = src_q;
        tag_d        = tag_q;
        flags_d      = flags_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            data_d       = alu_result;
            src_d        = sel;
            tag_d        = sel ? req1_tag : req0_tag;
            flags_d      = alu_flags;
            last_grant_d = sel;
        end
        unique case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (rsp_ready && !accept) state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            data_q       <= '0;
            src_q        <= 1'b0;
            tag_q        <= '0;
            flags_q      <= 3'b000;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            src_q        <= src_d;
            tag_q        <= tag_d;
            flags_q      <= flags_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        req0_ready = free && gnt0;
        req1_ready = free && gnt1;
        rsp_valid  = (state_q == ST_FULL);
        rsp_data   = data_q;
        rsp_src    = src_q;
        rsp_tag    = tag_q;
        rsp_flags  = flags_q;
    end

`ifdef ALU_CC_EN
    logic [2:0] cc_q, cc_d;

    always_comb begin
        cc_d = cc_q;
        if (accept && !sel && req0_setcc && !cc_hold) begin
            cc_d = alu_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q <= CC_RESET;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign cc = cc_q;
`else
    logic cc_ctrl_unused;

    assign cc_ctrl_unused = req0_setcc ^ cc_hold;
    assign cc             = CC_RESET;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - scoreboard bench for alu_share_arb; CC expectations follow ALU_CC_EN
module tb_alu_share_arb;

    logic        clk, rst;
    logic        req0_valid, req0_ready, req0_setcc;
    logic [1:0]  req0_fn;
    logic [63:0] req0_a, req0_b;
    logic [3:0]  req0_tag;
    logic        req1_valid, req1_ready;
    logic [1:0]  req1_fn;
    logic [63:0] req1_a, req1_b;
    logic [3:0]  req1_tag;
    logic        cc_hold, rsp_valid, rsp_ready, rsp_src;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic [2:0]  rsp_flags, cc;

    typedef struct packed {
        logic [63:0] data;
        logic        src;
        logic [3:0]  tag;
        logic [2:0]  flags;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    alu_share_arb #(.WIDTH(64), .TAGW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_fn    (req0_fn),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_tag   (req0_tag),
        .req0_setcc (req0_setcc),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_fn    (req1_fn),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_tag   (req1_tag),
        .cc_hold    (cc_hold),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_src    (rsp_src),
        .rsp_tag    (rsp_tag),
        .rsp_flags  (rsp_flags),
        .cc         (cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    function automatic logic [2:0] exp_cc(input logic [2:0] v);
`ifdef ALU_CC_EN
        return v;
`else
        return 3'b100;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                fail("rsp_unexpected");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_src", rsp_src, e.src);
                chk("rsp_tag", rsp_tag, e.tag);
                chk("rsp_flags", rsp_flags, e.flags);
            end
        end
    end

    task automatic issue(input bit src, input logic [1:0] fn, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] tag, input logic setcc, input logic hold,
                         input logic [63:0] exp_data, input logic [2:0] exp_flags, input logic [2:0] cc_after);
        bit ok;
        ok = 1'b0;
        req0_setcc = setcc;
        cc_hold    = hold;
        if (src) begin
            req1_fn = fn; req1_a = a; req1_b = b; req1_tag = tag; req1_valid = 1'b1;
        end else begin
            req0_fn = fn; req0_a = a; req0_b = b; req0_tag = tag; req0_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (src ? req1_ready : req0_ready) begin
                ok = 1'b1;
                exp_q.push_back('{exp_data, src, tag, exp_flags});
            end
        end
        if (!ok) fail("issue_accept");
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_setcc = 1'b0; cc_hold = 1'b0;
        chk("cc_after_op", cc, exp_cc(cc_after));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit drained;
        rst = 1'b1; rsp_ready = 1'b1; cc_hold = 1'b0;
        req0_valid = 0; req0_fn = 0; req0_a = 0; req0_b = 0; req0_tag = 0; req0_setcc = 0;
        req1_valid = 0; req1_fn = 0; req1_a = 0; req1_b = 0; req1_tag = 0;
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_src", rsp_src, 0);
        chk("reset_rsp_tag", rsp_tag, 0);
        chk("reset_rsp_flags", rsp_flags, 0);
        chk("reset_cc", cc, 3'b100);
        @(posedge clk);
        #1 rst = 1'b0;

        issue(0, 2'd2, 64'hF0F0F0F0F0F0F0F4, 64'hCCCCCCCCCCCCCCC5, 4'h1, 0, 0, 64'hC0C0C0C0C0C0C0C4, 3'b010, 3'b100);
        issue(0, 2'd1, 64'h1, 64'h8000000000000000, 4'h2, 1, 0, 64'h7FFFFFFFFFFFFFFF, 3'b001, 3'b001);
        issue(0, 2'd2, 64'hF0F0F0F0F0F0F0F4, 64'hCCCCCCCCCCCCCCC5, 4'h3, 1, 1, 64'hC0C0C0C0C0C0C0C4, 3'b010, 3'b001);
        issue(0, 2'd1, 64'h1, 64'h8000000000000000, 4'h4, 1, 1, 64'h7FFFFFFFFFFFFFFF, 3'b001, 3'b001);
        issue(0, 2'd0, 64'h7FFFFFFFFFFFFFFF, 64'h1, 4'h5, 1, 0, 64'h8000000000000000, 3'b011, 3'b011);
        issue(1, 2'd0, 64'h5, 64'hFFFFFFFFFFFFFFFB, 4'h6, 1, 0, 64'h0, 3'b100, 3'b011);
        issue(1, 2'd3, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 4'h7, 0, 0, 64'hF0F00F0FF0F00F0F, 3'b010, 3'b011);

        req0_fn = 2'd0; req0_a = 64'd1; req0_b = 64'd2; req0_tag = 4'h2; req0_valid = 1'b1;
        req1_fn = 2'd3; req1_a = 64'd3; req1_b = 64'd3; req1_tag = 4'h3; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_req0_ready", req0_ready, (i % 2) == 0);
            chk("rr_req1_ready", req1_ready, (i % 2) == 1);
            if (i > 0) chk("rr_rsp_valid", rsp_valid, 1);
            if ((i % 2) == 0) exp_q.push_back('{64'd3, 1'b0, 4'h2, 3'b000});
            else              exp_q.push_back('{64'd0, 1'b1, 4'h3, 3'b100});
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;

        rsp_ready = 1'b0;
        req0_fn = 2'd3; req0_a = 64'hFFFF0000FFFF0000; req0_b = 64'h0F0F0F0F0F0F0F0F; req0_tag = 4'h5; req0_valid = 1'b1;
        @(negedge clk);
        chk("stall_first_accept", req0_ready, 1);
        exp_q.push_back('{64'hF0F00F0FF0F00F0F, 1'b0, 4'h5, 3'b010});
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_fn = 2'd1; req1_a = 64'd3; req1_b = 64'd10; req1_tag = 4'h6; req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_req0_ready", req0_ready, 0);
            chk("stall_req1_ready", req1_ready, 0);
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_rsp_data", rsp_data, 64'hF0F00F0FF0F00F0F);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("unstall_same_cycle_accept", req1_ready, 1);
        exp_q.push_back('{64'd7, 1'b1, 4'h6, 3'b000});
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        rsp_ready = 1'b0;
        req0_fn = 2'd2; req0_a = 64'hF0F0F0F0F0F0F0F4; req0_b = 64'hCCCCCCCCCCCCCCC5; req0_tag = 4'h8;
        req0_setcc = 1'b1; req0_valid = 1'b1;
        @(negedge clk);
        chk("inflight_accept", req0_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req0_setcc = 1'b0;
        chk("inflight_cc", cc, exp_cc(3'b010));
        chk("inflight_rsp_valid", rsp_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rsp_valid", rsp_valid, 0);
        chk("async_rst_cc", cc, 3'b100);
        chk("async_rst_rsp_data", rsp_data, 0);
        chk("async_rst_rsp_flags", rsp_flags, 0);
        @(posedge clk);
        #1;
        rst = 1'b0; rsp_ready = 1'b1;

        req0_fn = 2'd0; req0_a = 64'd2; req0_b = 64'd3; req0_tag = 4'h9; req0_valid = 1'b1;
        req1_fn = 2'd1; req1_a = 64'd5; req1_b = 64'd5; req1_tag = 4'hA; req1_valid = 1'b1;
        @(negedge clk);
        chk("first_tie_req0_ready", req0_ready, 1);
        chk("first_tie_req1_ready", req1_ready, 0);
        exp_q.push_back('{64'd5, 1'b0, 4'h9, 3'b000});
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("second_req1_ready", req1_ready, 1);
        exp_q.push_back('{64'd0, 1'b1, 4'hA, 3'b100});
        @(posedge clk);
        #1;
        req1_valid = 1'b0;

        drained = 1'b0;
        for (int i = 0; i < 10 && !drained; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) drained = 1'b1;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("final_cc", cc, 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
